// File: rtl/local_sram_arbiter_pkg.sv
// local_sram_arbiter_pkg: shared state/grant encodings and default sizes for the SRAM arbiter
package local_sram_arbiter_pkg;
  localparam int SRAM_ADDRESS_SIZE_DEF = 9;
  localparam int ADDRESS_WIDTH_DEF = 24;
  localparam int MAX_WAIT_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESPOND = 2'd2} state_e;
  typedef enum logic [1:0] {GRANT_NONE = 2'd0, GRANT_PRIMARY = 2'd1, GRANT_SECONDARY = 2'd2} grant_e;
endpackage

// File: rtl/local_sram_arbiter_if.sv
// local_sram_arbiter_if: enable/busy requester bus; master is the requester, slave the arbiter
interface local_sram_arbiter_if #(parameter int ADDRESS_WIDTH = 24);
  logic enable;
  logic write_enable;
  logic [ADDRESS_WIDTH-1:0] address;
  logic [3:0] byte_select;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic busy;
  modport master (output enable, write_enable, address, byte_select, data_write, input data_read, busy);
  modport slave (input enable, write_enable, address, byte_select, data_write, output data_read, busy);
endinterface

// File: rtl/local_sram_wait_counter.sv
// local_sram_wait_counter: saturating count of cycles the secondary requester has been kept waiting
module local_sram_wait_counter #(parameter int MAX_WAIT = 4) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       increment,
  output logic       at_limit
);
  logic [3:0] count_q, count_d;
  assign at_limit = count_q == 4'(MAX_WAIT);
  always_comb count_d = clear ? 4'd0 : (increment && !at_limit) ? count_q + 4'd1 : count_q;
  always_ff @(posedge clk) count_q <= !rst_n ? 4'd0 : count_d;
endmodule

// File: rtl/local_sram_arbiter.sv
// local_sram_arbiter: shares one SRAM rw port between primary and secondary requesters, IDLE->ACCESS->RESPOND
module local_sram_arbiter
  import local_sram_arbiter_pkg::*;
#(
  parameter int SRAM_ADDRESS_SIZE = SRAM_ADDRESS_SIZE_DEF,
  parameter int ADDRESS_WIDTH = ADDRESS_WIDTH_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic                         wb_clk_i,
  input  logic                         wb_rst_i,
  local_sram_arbiter_if.slave          primary,
  local_sram_arbiter_if.slave          secondary,
  output logic                         sram_primarySelect,
  output logic                         sram_primaryWriteEnable,
  output logic [3:0]                   sram_primaryWriteMask,
  output logic [SRAM_ADDRESS_SIZE-1:0] sram_primaryAddress,
  output logic [31:0]                  sram_primaryDataWrite,
  input  logic [31:0]                  sram_primaryDataRead
);
  state_e state_q, state_d;
  grant_e grant_q, grant_d;
  logic we_q, we_d;
  logic [3:0] bsel_q, bsel_d;
  logic [SRAM_ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [31:0] dw_q, dw_d;
  logic at_limit, win_sec, take, resp_p, resp_s, wait_clear, wait_inc;
  logic unused_addr;
  assign unused_addr = ^{primary.address[ADDRESS_WIDTH-1:SRAM_ADDRESS_SIZE+2], primary.address[1:0],
                         secondary.address[ADDRESS_WIDTH-1:SRAM_ADDRESS_SIZE+2], secondary.address[1:0]};
  // Secondary wins when starved to the limit or when primary is not asking at all
  assign win_sec = secondary.enable && (at_limit || !primary.enable);
  assign take = state_q == IDLE && (primary.enable || secondary.enable);
  assign wait_clear = state_q == IDLE && win_sec;
  assign wait_inc = secondary.enable && !wait_clear && grant_q != GRANT_SECONDARY;
  local_sram_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_i),
    .clear     (wait_clear),
    .increment (wait_inc),
    .at_limit  (at_limit)
  );
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= GRANT_NONE;
      we_q <= 1'b0;
      bsel_q <= 4'd0;
      addr_q <= '0;
      dw_q <= 32'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      we_q <= we_d;
      bsel_q <= bsel_d;
      addr_q <= addr_d;
      dw_q <= dw_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE ? (take ? ACCESS : IDLE) : state_q == ACCESS ? RESPOND : IDLE;
    grant_d = state_q == IDLE ? (win_sec ? GRANT_SECONDARY : primary.enable ? GRANT_PRIMARY : GRANT_NONE)
            : state_q == RESPOND ? GRANT_NONE : grant_q;
    we_d = take ? (win_sec ? secondary.write_enable : primary.write_enable) : we_q;
    bsel_d = take ? (win_sec ? secondary.byte_select : primary.byte_select) : bsel_q;
    addr_d = take ? (win_sec ? secondary.address[SRAM_ADDRESS_SIZE+1:2] : primary.address[SRAM_ADDRESS_SIZE+1:2]) : addr_q;
    dw_d = take ? (win_sec ? secondary.data_write : primary.data_write) : dw_q;
  end
  always_comb begin
    sram_primarySelect = state_q == ACCESS;
    sram_primaryWriteEnable = sram_primarySelect && we_q;
    sram_primaryWriteMask = sram_primarySelect ? bsel_q & {4{we_q}} : 4'd0;
    sram_primaryAddress = sram_primarySelect ? addr_q : '0;
    sram_primaryDataWrite = sram_primarySelect ? dw_q : 32'd0;
    resp_p = state_q == RESPOND && grant_q == GRANT_PRIMARY;
    resp_s = state_q == RESPOND && grant_q == GRANT_SECONDARY;
  end
  assign primary.busy = primary.enable && !resp_p;
  assign secondary.busy = secondary.enable && !resp_s;
  assign primary.data_read = resp_p ? sram_primaryDataRead : 32'd0;
  assign secondary.data_read = resp_s ? sram_primaryDataRead : 32'd0;
endmodule
